// File: rtl/mseq_bit_checker_if.sv
// Bus between the DPLL-side stimulus and the m-sequence bit checker.
// master drives received data/clock/lock, slave (the checker) drives status.
interface mseq_bit_checker_if;
  logic        m_seq_in;
  logic        recovered_clk;
  logic        pll_locked;
  logic        seq_synced;
  logic        bit_err;
  logic        win_done;
  logic [15:0] err_cnt;

  modport master (
    output m_seq_in, recovered_clk, pll_locked,
    input  seq_synced, bit_err, win_done, err_cnt
  );

  modport slave (
    input  m_seq_in, recovered_clk, pll_locked,
    output seq_synced, bit_err, win_done, err_cnt
  );
endinterface

// File: rtl/mseq_bit_checker.sv
// M-sequence bit-error checker: samples data on recovered-clock rising edges, self-syncs a local LFSR, counts errors per window.
// Latency: bit_err/win_done one cycle after the internal bit strobe (3 cycles after recovered_clk rise); no backpressure.
module mseq_bit_checker #(
  parameter int LFSR_LEN = 7,
  parameter int TAP      = 6,
  parameter int WIN_BITS = 1000,
  parameter int ERR_THR  = 8
) (
  input  logic                clk_2m,
  input  logic                rst_n,
  mseq_bit_checker_if.slave   bus
);

  localparam int LCW = $clog2(LFSR_LEN);
  localparam logic [LCW-1:0] LOAD_LAST = LCW'(LFSR_LEN - 1);
  localparam logic [15:0]    WIN_LAST  = 16'(WIN_BITS - 1);
  localparam logic [15:0]    THR       = 16'(ERR_THR);

  typedef enum logic [1:0] {HUNT, LOAD, CHECK} state_t;

  logic                r_seq_s1, r_seq_s2;
  logic                r_clk_s1, r_clk_s2, r_clk_s3;
  logic                r_lock_s1, r_lock_s2;
  state_t              r_state;
  logic [LFSR_LEN-1:0] r_shreg;
  logic [LCW-1:0]      r_load_cnt;
  logic [15:0]         r_win_cnt;
  logic [15:0]         r_win_err;
  logic [15:0]         r_err_cnt;
  logic                r_seq_synced;
  logic                r_bit_err;
  logic                r_win_done;

  state_t              w_state_nxt;
  logic [LFSR_LEN-1:0] w_shreg_nxt;
  logic [LCW-1:0]      w_load_cnt_nxt;
  logic [15:0]         w_win_cnt_nxt;
  logic [15:0]         w_win_err_nxt;
  logic [15:0]         w_err_cnt_nxt;
  logic                w_synced_nxt;
  logic                w_bit_err_nxt;
  logic                w_win_done_nxt;
  logic                w_bit_stb;
  logic                w_expected;
  logic                w_mismatch;
  logic [15:0]         w_err_sum;
  logic [LFSR_LEN-1:0] w_loaded;

  // Data and clock share the same sync depth so the sample stays at bit centre
  always_ff @(posedge clk_2m or negedge rst_n) begin
    if (!rst_n) begin
      r_seq_s1  <= 1'b0;
      r_seq_s2  <= 1'b0;
      r_clk_s1  <= 1'b0;
      r_clk_s2  <= 1'b0;
      r_clk_s3  <= 1'b0;
      r_lock_s1 <= 1'b0;
      r_lock_s2 <= 1'b0;
    end else begin
      r_seq_s1  <= bus.m_seq_in;
      r_seq_s2  <= r_seq_s1;
      r_clk_s1  <= bus.recovered_clk;
      r_clk_s2  <= r_clk_s1;
      r_clk_s3  <= r_clk_s2;
      r_lock_s1 <= bus.pll_locked;
      r_lock_s2 <= r_lock_s1;
    end
  end

  assign w_bit_stb = r_clk_s2 & ~r_clk_s3;

  always_ff @(posedge clk_2m or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= HUNT;
      r_shreg      <= '0;
      r_load_cnt   <= '0;
      r_win_cnt    <= '0;
      r_win_err    <= '0;
      r_err_cnt    <= '0;
      r_seq_synced <= 1'b0;
      r_bit_err    <= 1'b0;
      r_win_done   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shreg      <= w_shreg_nxt;
      r_load_cnt   <= w_load_cnt_nxt;
      r_win_cnt    <= w_win_cnt_nxt;
      r_win_err    <= w_win_err_nxt;
      r_err_cnt    <= w_err_cnt_nxt;
      r_seq_synced <= w_synced_nxt;
      r_bit_err    <= w_bit_err_nxt;
      r_win_done   <= w_win_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_shreg_nxt    = r_shreg;
    w_load_cnt_nxt = r_load_cnt;
    w_win_cnt_nxt  = r_win_cnt;
    w_win_err_nxt  = r_win_err;
    w_err_cnt_nxt  = r_err_cnt;
    w_synced_nxt   = r_seq_synced;
    w_bit_err_nxt  = 1'b0;
    w_win_done_nxt = 1'b0;
    w_expected     = r_shreg[LFSR_LEN-1] ^ r_shreg[TAP-1];
    w_mismatch     = w_bit_stb & (r_seq_s2 ^ w_expected);
    w_err_sum      = (w_mismatch && (r_win_err != 16'hFFFF)) ? r_win_err + 16'd1 : r_win_err;
    w_loaded       = {r_shreg[LFSR_LEN-2:0], r_seq_s2};

    // Loss of lock overrides everything, including a coincident window end
    if (!r_lock_s2) begin
      w_state_nxt    = HUNT;
      w_synced_nxt   = 1'b0;
      w_load_cnt_nxt = '0;
      w_win_cnt_nxt  = '0;
      w_win_err_nxt  = '0;
    end else begin
      case (r_state)
        HUNT: begin
          w_load_cnt_nxt = '0;
          w_win_cnt_nxt  = '0;
          w_win_err_nxt  = '0;
          w_state_nxt    = LOAD;
        end
        LOAD: begin
          if (w_bit_stb) begin
            w_shreg_nxt = w_loaded;
            if (r_load_cnt == LOAD_LAST) begin
              w_load_cnt_nxt = '0;
              w_win_cnt_nxt  = '0;
              w_win_err_nxt  = '0;
              if (w_loaded != '0) w_state_nxt = CHECK;
            end else begin
              w_load_cnt_nxt = r_load_cnt + 1'b1;
            end
          end
        end
        CHECK: begin
          if (w_bit_stb) begin
            // Shift in the expected bit so a channel error is counted once
            w_shreg_nxt   = {r_shreg[LFSR_LEN-2:0], w_expected};
            w_bit_err_nxt = w_mismatch;
            if (r_win_cnt == WIN_LAST) begin
              w_err_cnt_nxt  = w_err_sum;
              w_win_done_nxt = 1'b1;
              w_win_cnt_nxt  = '0;
              w_win_err_nxt  = '0;
              if (w_err_sum >= THR) begin
                w_synced_nxt   = 1'b0;
                w_state_nxt    = LOAD;
                w_load_cnt_nxt = '0;
              end else begin
                w_synced_nxt = 1'b1;
              end
            end else begin
              w_win_cnt_nxt = r_win_cnt + 16'd1;
              w_win_err_nxt = w_err_sum;
            end
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  assign bus.seq_synced = r_seq_synced;
  assign bus.bit_err    = r_bit_err;
  assign bus.win_done   = r_win_done;
  assign bus.err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_mseq_bit_checker.sv
// Directed bench for mseq_bit_checker: sync, single/burst errors, zero data, lock loss and reset.
module tb_mseq_bit_checker;
  localparam int WIN = 100;

  logic clk_2m = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_2m = ~clk_2m;

  mseq_bit_checker_if bus();

  mseq_bit_checker #(
    .LFSR_LEN(7), .TAP(6), .WIN_BITS(WIN), .ERR_THR(8)
  ) dut (
    .clk_2m (clk_2m),
    .rst_n  (rst_n),
    .bus    (bus.slave)
  );

  logic seq [0:126];
  int   idx;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   be_cyc   = 0;
  int   wd_cyc   = 0;
  int   be_ref;
  int   wd_ref;
  int   flip;

  always @(negedge clk_2m) begin
    if (bus.bit_err)  be_cyc = be_cyc + 1;
    if (bus.win_done) wd_cyc = wd_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.m_seq_in      = b;
    bus.recovered_clk = 1'b0;
    repeat (4) @(negedge clk_2m);
    bus.recovered_clk = 1'b1;
    repeat (4) @(negedge clk_2m);
  endtask

  // Sends n bits of the reference sequence, inverting absolute bit numbers lo..hi
  task automatic send_seq(input int n, input int lo, input int hi);
    logic b;
    for (int i = 0; i < n; i++) begin
      b = seq[idx % 127];
      if (idx >= lo && idx <= hi) b = ~b;
      send_bit(b);
      idx++;
    end
  endtask

  task automatic settle();
    repeat (2) @(negedge clk_2m);
    #1;
  endtask

  task automatic relock();
    bus.pll_locked = 1'b0;
    repeat (4) @(negedge clk_2m);
    bus.pll_locked = 1'b1;
    repeat (4) @(negedge clk_2m);
  endtask

  initial begin
    for (int i = 0; i < 7; i++) seq[i] = (i == 0);
    for (int i = 7; i < 127; i++) seq[i] = seq[i-7] ^ seq[i-6];
    idx = 0;
    bus.m_seq_in      = 1'b0;
    bus.recovered_clk = 1'b0;
    bus.pll_locked    = 1'b0;

    repeat (3) @(negedge clk_2m);
    #1;
    chk("rst_synced",  {31'd0, bus.seq_synced}, 0);
    chk("rst_bit_err", {31'd0, bus.bit_err},    0);
    chk("rst_win_done",{31'd0, bus.win_done},   0);
    chk("rst_err_cnt", {16'd0, bus.err_cnt},    0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_2m);
    bus.pll_locked = 1'b1;
    repeat (4) @(negedge clk_2m);

    // First window ends on bit 107 (7 load + WIN check)
    send_seq(106, -1, -1);
    settle();
    chk("w1_pre_synced", {31'd0, bus.seq_synced}, 0);
    chk("w1_pre_wd",     wd_cyc, 0);
    send_seq(1, -1, -1);
    settle();
    chk("w1_wd",     wd_cyc, 1);
    chk("w1_err",    {16'd0, bus.err_cnt}, 0);
    chk("w1_synced", {31'd0, bus.seq_synced}, 1);
    chk("w1_be",     be_cyc, 0);

    send_seq(WIN, 150, 150);
    settle();
    chk("w2_be",     be_cyc, 1);
    chk("w2_wd",     wd_cyc, 2);
    chk("w2_err",    {16'd0, bus.err_cnt}, 1);
    chk("w2_synced", {31'd0, bus.seq_synced}, 1);

    send_seq(WIN, 220, 229);
    settle();
    chk("w3_err",    {16'd0, bus.err_cnt}, 10);
    chk("w3_synced", {31'd0, bus.seq_synced}, 0);
    chk("w3_be",     be_cyc, 11);
    chk("w3_wd",     wd_cyc, 3);

    // Resync: 7 load bits + window with one error at bit 350
    send_seq(106, 350, 350);
    settle();
    chk("rs_pre_synced", {31'd0, bus.seq_synced}, 0);
    send_seq(1, -1, -1);
    settle();
    chk("rs_synced", {31'd0, bus.seq_synced}, 1);
    chk("rs_err",    {16'd0, bus.err_cnt}, 1);
    chk("rs_wd",     wd_cyc, 4);
    chk("rs_be",     be_cyc, 12);

    // Lock loss mid-window
    send_seq(50, -1, -1);
    @(negedge clk_2m);
    bus.pll_locked = 1'b0;
    repeat (2) @(negedge clk_2m);
    #1;
    chk("ll_synced_2cyc", {31'd0, bus.seq_synced}, 1);
    @(negedge clk_2m);
    #1;
    chk("ll_synced_3cyc", {31'd0, bus.seq_synced}, 0);
    chk("ll_err_hold",    {16'd0, bus.err_cnt}, 1);
    send_seq(60, -1, -1);
    settle();
    chk("ll_no_wd", wd_cyc, 4);
    bus.pll_locked = 1'b1;
    repeat (4) @(negedge clk_2m);
    send_seq(106, -1, -1);
    settle();
    chk("rl_pre_synced", {31'd0, bus.seq_synced}, 0);
    send_seq(1, -1, -1);
    settle();
    chk("rl_synced", {31'd0, bus.seq_synced}, 1);
    chk("rl_err",    {16'd0, bus.err_cnt}, 0);
    chk("rl_wd",     wd_cyc, 5);

    // All-zero data keeps reloading
    relock();
    be_ref = be_cyc;
    for (int i = 0; i < 300; i++) send_bit(1'b0);
    settle();
    chk("z_wd",     wd_cyc, 5);
    chk("z_be",     be_cyc, be_ref);
    chk("z_synced", {31'd0, bus.seq_synced}, 0);

    // Reset mid-window
    relock();
    flip = idx + 57;
    send_seq(107, flip, flip);
    settle();
    chk("pr_err",    {16'd0, bus.err_cnt}, 1);
    chk("pr_synced", {31'd0, bus.seq_synced}, 1);
    send_seq(30, -1, -1);
    @(negedge clk_2m);
    rst_n = 1'b0;
    #1;
    chk("ar_synced",  {31'd0, bus.seq_synced}, 0);
    chk("ar_err",     {16'd0, bus.err_cnt}, 0);
    chk("ar_bit_err", {31'd0, bus.bit_err}, 0);
    chk("ar_wd",      {31'd0, bus.win_done}, 0);
    be_ref = be_cyc;
    wd_ref = wd_cyc;
    for (int i = 0; i < 20; i++) send_bit(i[0]);
    settle();
    chk("ar_no_be", be_cyc, be_ref);
    chk("ar_no_wd", wd_cyc, wd_ref);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_2m);
    #1;
    chk("post_rst_synced", {31'd0, bus.seq_synced}, 0);
    chk("post_rst_err",    {16'd0, bus.err_cnt}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
